// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, constants and round-robin search helper for arbitri_8ne1
package arb_pkg;

    typedef enum logic {
        PRITJE = 1'b0,
        LEJE   = 1'b1
    } state_t;

    localparam int N_HYRJE = 8;
    localparam int SEL_W   = 3;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } winner_t;

    // Scans start, start+1, ... mod 8; descending loop so the smallest offset wins.
    function automatic winner_t next_winner(input logic [7:0] req, input logic [2:0] start);
        winner_t    r;
        logic [2:0] k;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            k = start + 3'(i);
            if (req[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_zgjedhes.sv
// rtl/rr_zgjedhes.sv - combinational rotate-priority encoder: first unmasked request from start
module rr_zgjedhes
    import arb_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] start,
    input  logic [7:0] mask,
    output logic       valid,
    output logic [2:0] idx
);

    winner_t w;

    assign w     = next_winner(req & ~mask, start);
    assign valid = w.found;
    assign idx   = w.idx;

endmodule

// File: rtl/arbitri_8ne1.sv
// rtl/arbitri_8ne1.sv - 8-requester round-robin arbiter with bounded hold driving the 8-to-1 select
// Optional grant lock via Bllokim when ARB_LOCK_EN is defined.
module arbitri_8ne1
    import arb_pkg::*;
#(
    parameter int MAX_MBAJTJE = 4
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [7:0] Kerkesa,
    input  logic       Bllokim,
    output logic [7:0] Leje,
    output logic [2:0] S,
    output logic       Aktiv,
    output logic [2:0] Fitues
);

    localparam logic [3:0] CNT_MAX = 4'(MAX_MBAJTJE - 1);

    state_t     state_q, state_d;
    logic [7:0] leje_q, leje_d;
    logic [2:0] s_q, s_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;

    logic       lock_w;
    logic [7:0] mask;
    logic       arb_valid;
    logic [2:0] arb_idx;

`ifdef ARB_LOCK_EN
    assign lock_w = Bllokim;
`else
    logic unused_bllokim;
    assign unused_bllokim = Bllokim;
    assign lock_w         = 1'b0;
`endif

    // While granted, ptr equals the winner, so excluding it makes the search a preemption search.
    assign mask = (state_q == LEJE) ? (8'd1 << s_q) : 8'd0;

    rr_zgjedhes u_zgjedhes (
        .req   (Kerkesa),
        .start (ptr_q + 3'd1),
        .mask  (mask),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        leje_d  = leje_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            PRITJE: begin
                if (arb_valid) begin
                    state_d = LEJE;
                    leje_d  = 8'd1 << arb_idx;
                    s_d     = arb_idx;
                    ptr_d   = arb_idx;
                    cnt_d   = '0;
                end
            end
            LEJE: begin
                if (!Kerkesa[s_q] || (cnt_q == CNT_MAX && arb_valid && !lock_w)) begin
                    if (arb_valid) begin
                        leje_d = 8'd1 << arb_idx;
                        s_d    = arb_idx;
                        ptr_d  = arb_idx;
                        cnt_d  = '0;
                    end else begin
                        state_d = PRITJE;
                        leje_d  = '0;
                        cnt_d   = '0;
                    end
                end else if (!lock_w && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = PRITJE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= PRITJE;
            leje_q  <= '0;
            s_q     <= '0;
            ptr_q   <= 3'd7;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            leje_q  <= leje_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Leje   = leje_q;
    assign S      = s_q;
    assign Fitues = s_q;
    assign Aktiv  = (state_q == LEJE);

endmodule

// File: tb/tb_arbitri_8ne1.sv
// tb/tb_arbitri_8ne1.sv - directed table-driven bench for arbitri_8ne1 (lock sequence under ARB_LOCK_EN)
module tb_arbitri_8ne1;

    localparam int MAXH = 4;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] Kerkesa = 8'h00;
    logic       Bllokim = 1'b0;
    logic [7:0] Leje;
    logic [2:0] S;
    logic       Aktiv;
    logic [2:0] Fitues;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] k;
        logic [7:0] leje;
        logic [2:0] s;
        logic       aktiv;
    } vec_t;

    vec_t vecs[16];

    arbitri_8ne1 #(.MAX_MBAJTJE(MAXH)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Kerkesa (Kerkesa),
        .Bllokim (Bllokim),
        .Leje    (Leje),
        .S       (S),
        .Aktiv   (Aktiv),
        .Fitues  (Fitues)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_grant(input string name, input logic [7:0] l, input logic [2:0] s, input logic a);
        chk({name, " leje"}, int'(Leje), int'(l));
        chk({name, " s"}, int'(S), int'(s));
        chk({name, " fitues"}, int'(Fitues), int'(s));
        chk({name, " aktiv"}, int'(Aktiv), int'(a));
    endtask

    task automatic do_reset();
        Kerkesa = 8'h00;
        Bllokim = 1'b0;
        #2 Reset_n = 1'b0;
        #3 Reset_n = 1'b1;
        step();
    endtask

    int served_at[8];
    int exp_s;

    initial begin
        vecs[0]  = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[1]  = '{8'h00, 8'h00, 3'd0, 1'b0};
        vecs[2]  = '{8'h00, 8'h00, 3'd0, 1'b0};
        vecs[3]  = '{8'h0C, 8'h04, 3'd2, 1'b1};
        vecs[4]  = '{8'h0C, 8'h04, 3'd2, 1'b1};
        vecs[5]  = '{8'h08, 8'h08, 3'd3, 1'b1};
        vecs[6]  = '{8'h08, 8'h08, 3'd3, 1'b1};
        vecs[7]  = '{8'h20, 8'h20, 3'd5, 1'b1};
        vecs[8]  = '{8'h21, 8'h20, 3'd5, 1'b1};
        vecs[9]  = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[10] = '{8'h00, 8'h00, 3'd0, 1'b0};
        vecs[11] = '{8'hC0, 8'h40, 3'd6, 1'b1};
        vecs[12] = '{8'h80, 8'h80, 3'd7, 1'b1};
        vecs[13] = '{8'h00, 8'h00, 3'd7, 1'b0};
        vecs[14] = '{8'h81, 8'h01, 3'd0, 1'b1};
        vecs[15] = '{8'h00, 8'h00, 3'd0, 1'b0};

        #3;
        chk_grant("reset", 8'h00, 3'd0, 1'b0);
        #4 Reset_n = 1'b1;
        step();
        chk_grant("post_reset", 8'h00, 3'd0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            Kerkesa = vecs[i].k;
            step();
            chk_grant($sformatf("vec%0d", i), vecs[i].leje, vecs[i].s, vecs[i].aktiv);
        end

        // Two requesters alternate every MAXH cycles with no idle gap.
        do_reset();
        Kerkesa = 8'h84;
        for (int k = 0; k < 6 * MAXH; k++) begin
            step();
            exp_s = ((k / MAXH) % 2 == 0) ? 2 : 7;
            chk_grant($sformatf("alt%0d", k), 8'd1 << exp_s, 3'(exp_s), 1'b1);
        end

        // All requesting: strict rotation, everyone served within 7*MAXH+1 cycles.
        do_reset();
        for (int i = 0; i < 8; i++) served_at[i] = -1;
        Kerkesa = 8'hFF;
        for (int k = 0; k < 10 * MAXH; k++) begin
            step();
            exp_s = (k / MAXH) % 8;
            chk($sformatf("rot%0d s", k), int'(S), exp_s);
            chk($sformatf("rot%0d leje", k), int'(Leje), 1 << exp_s);
            if (served_at[S] < 0) served_at[S] = k + 1;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (served_at[i] < 0 || served_at[i] > 7 * MAXH + 1) begin
                errors++;
                $display("FAIL wait%0d: served at %0d expected 1..%0d", i, served_at[i], 7 * MAXH + 1);
            end
        end

        // Asynchronous reset mid-grant, then reset priority applies.
        do_reset();
        Kerkesa = 8'h40;
        step();
        chk_grant("pre_async", 8'h40, 3'd6, 1'b1);
        #2 Reset_n = 1'b0;
        #1;
        chk_grant("async_rst", 8'h00, 3'd0, 1'b0);
        Kerkesa = 8'h41;
        #2 Reset_n = 1'b1;
        step();
        chk_grant("after_rst", 8'h01, 3'd0, 1'b1);

`ifdef ARB_LOCK_EN
        do_reset();
        Kerkesa = 8'h02;
        step();
        chk_grant("lock_grant", 8'h02, 3'd1, 1'b1);
        Kerkesa = 8'h06;
        Bllokim = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_grant($sformatf("lock%0d", k), 8'h02, 3'd1, 1'b1);
        end
        Bllokim = 1'b0;
        for (int k = 0; k < MAXH - 1; k++) begin
            step();
            chk_grant($sformatf("unlock%0d", k), 8'h02, 3'd1, 1'b1);
        end
        step();
        chk_grant("unlock_move", 8'h04, 3'd2, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbitri_8ne1.md
Name: arbitri_8ne1

Overview:
- Round-robin arbiter that shares the 8-to-1 selector between eight requesters.
- Drives the selector's 3-bit select S and a one-hot grant vector, so exactly one source reaches the shared 24-bit destination per cycle (register-file write port / ALU operand bus).
- Bounded hold time ensures fairness; grant changes land on clock edges only.

Parameters:
- N_HYRJE, 8, number of requesters (fixed at 8; S is 3 bits).
- MAX_MBAJTJE, 4, max consecutive cycles one requester keeps the grant while others wait (legal range 1..15).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Kerkesa  input  8  request per requester; bit i held high while requester i wants the resource.
- Leje  output  8  one-hot grant, registered; all-zero when idle.
- S  output  3  select to the 8-to-1 selector, registered; equals the index of the Leje bit.
- Aktiv  output  1  high when any grant is active (Leje != 0).
- Fitues  output  3  index of the current winner (same as S; kept separate for debug and trace).
- Bllokim  input  1  lock request. Used only with ARB_LOCK_EN; ignored otherwise.

Behaviour:
- Reset (asynchronous assert, synchronous release): Leje=0, S=0, Fitues=0, Aktiv=0, state=PRITJE, hold counter cnt=0, last-grant pointer ptr=7. With ptr=7, index 0 has first priority after reset.
- State PRITJE (idle):
  - If Kerkesa==0, stay.
  - Otherwise, at the next edge, grant the first set bit searching ptr+1, ptr+2, … mod 8. Set Leje/S/Fitues, set ptr=winner, cnt=0, go to LEJE.
  - Latency from a request to its grant is one cycle.
- State LEJE (grant active, winner w). Evaluated each edge:
  - a) Kerkesa[w]=0: re-arbitrate among Kerkesa, searching from w+1. If any request is set, grant it directly with no idle bubble, cnt=0. If none, go to PRITJE with Leje=0; S and Fitues hold their last value.
  - b) Kerkesa[w]=1, cnt==MAX_MBAJTJE-1, and another bit is set: preempt. Grant the next requester from w+1, excluding w, cnt=0.
  - c) Otherwise: keep w, cnt=min(cnt+1, MAX_MBAJTJE-1), saturating.
- A requester alone on the bus keeps the grant indefinitely.
- Leje is always one-hot or zero. S is never changed mid-cycle.
- Aktiv = (state==LEJE), registered together with Leje.
- A request dropped and re-raised in the same cycle it loses the grant waits for its round-robin turn.
- Simultaneous requests: the round-robin order from ptr+1 decides.
- Reset asserted mid-grant: Leje drops to 0 immediately (asynchronous). The first grant after reset follows the reset priority (index 0 first).
- Worst-case wait for a continuously requesting input: 7*MAX_MBAJTJE cycles + 1.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined: while Bllokim=1 and state=LEJE, preemption (b) is suppressed, the grant stays with w, and cnt freezes. Rule (a) still applies, so dropping the request releases the grant even if Bllokim=1. Bllokim is sampled in the same edge evaluation as Kerkesa.
- Not defined: the Bllokim port exists but is unused; behaviour is exactly as above.

Decomposition:
- Shared package arb_pkg:
  - state encoding: PRITJE=1'b0, LEJE=1'b1
  - constant N_HYRJE=8 and select width 3
  - function next_winner(req[7:0], start[2:0]) returning found flag + index
- One natural sub-module: rr_zgjedhes, a combinational rotate-priority encoder (8 inputs, start index, mask) returning valid + 3-bit index.
- arbitri_8ne1 instantiates rr_zgjedhes and holds the FSM, counter and output registers. The select S connects directly to the existing 8-to-1 selector.

Test Plan:
- Reset, then Kerkesa=8'b0000_0001 -> one cycle later Leje=0000_0001, S=0, Aktiv=1. Drop the request -> next edge Leje=0, Aktiv=0, S stays 0.
- Kerkesa=8'b1000_0100 held constant, MAX_MBAJTJE=4 -> grant 2 for 4 cycles, then 7 for 4, then 2 for 4, alternating. Leje is never zero between them.
- Kerkesa=8'hFF held -> grants rotate 0,1,2,…,7,0, each held 4 cycles. Check that every index is served within 29 cycles.
- Winner 3 active at cnt=1, Kerkesa changes from 0000_1000 to 0010_0000 -> next edge S=5, cnt=0, no idle cycle.
- Reset_n pulsed low mid-grant (S=6) -> Leje=0 without waiting for an edge. After release with Kerkesa=0100_0001 -> grant index 0 first.
- With ARB_LOCK_EN: grant at 1, Kerkesa=0000_0110, Bllokim=1 for 10 cycles -> S stays 1 all 10 cycles. Bllokim=0 -> after cnt reaches 3, grant moves to 2.
